// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg : shared constants and state type for the SPI target front end
// Revision: 1.0
// ============================================================================
package spi_pkg;
  localparam int SPI_FRAME_BITS = 8;
  localparam int BIT_CNT_W = $clog2(SPI_FRAME_BITS);
  localparam logic [SPI_FRAME_BITS-1:0] FILL_BYTE_DEFAULT = 8'h00;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;
endpackage
`default_nettype wire

// File: rtl/spi_device_if.sv
`default_nettype none
// ============================================================================
// spi_device_if : SPI pins plus byte-level rx/tx handshake of spi_device
// Revision: 1.0
// ============================================================================
interface spi_device_if;
  import spi_pkg::*;

  logic                      spi_sck;
  logic                      spi_cs_n;
  logic                      spi_copi;
  logic                      spi_cipo;
  logic [SPI_FRAME_BITS-1:0] spi_rx_data;
  logic                      spi_rx_strobe;
  logic [SPI_FRAME_BITS-1:0] spi_tx_data;
  logic                      spi_tx_strobe;
  logic                      tx_underrun;

  modport slave (
    input  spi_sck, spi_cs_n, spi_copi, spi_tx_data, spi_tx_strobe,
    output spi_cipo, spi_rx_data, spi_rx_strobe, tx_underrun
  );

  modport master (
    output spi_sck, spi_cs_n, spi_copi, spi_tx_data, spi_tx_strobe,
    input  spi_cipo, spi_rx_data, spi_rx_strobe, tx_underrun
  );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : single-bit synchroniser with configurable reset value
// Revision: 1.0
// ============================================================================
module sync_2ff
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];
endmodule
`default_nettype wire

// File: rtl/spi_device.sv
`default_nettype none
// ============================================================================
// spi_device : mode-0 SPI target, oversampled in clk, byte strobes in/out
// Revision: 1.0
// ============================================================================
module spi_device
  import spi_pkg::*;
#(
  parameter logic [SPI_FRAME_BITS-1:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  spi_device_if.slave  bus
);
  logic w_sck_s, w_cs_s, w_copi_s;
  logic r_sck_d;
  spi_state_e r_state, w_state_nxt;

  logic [SPI_FRAME_BITS-2:0] r_rx_shift;
  logic [SPI_FRAME_BITS-1:0] r_rx_data, r_tx_shift, r_tx_hold, w_tx_next;
  logic [BIT_CNT_W-1:0]      r_bit_count;
  logic r_rx_strobe, r_tx_underrun, r_hold_valid, r_byte_done;
  logic w_sel, w_rise, w_fall, w_cs_fall, w_load, w_shift, w_last_bit;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync_sck  (.clk(clk), .reset_n(reset_n), .i_d(bus.spi_sck),  .o_q(w_sck_s));
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset_n(reset_n), .i_d(bus.spi_cs_n), .o_q(w_cs_s));
  sync_2ff #(.RESET_VAL(1'b0)) u_sync_copi (.clk(clk), .reset_n(reset_n), .i_d(bus.spi_copi), .o_q(w_copi_s));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_d <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_sck_d <= w_sck_s;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!w_cs_s) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_cs_s)  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_sel      = ~w_cs_s;
  assign w_cs_fall  = (r_state == ST_IDLE) && w_sel;
  assign w_rise     = w_sel & w_sck_s & ~r_sck_d;
  assign w_fall     = w_sel & ~w_sck_s & r_sck_d;
  assign w_last_bit = (r_bit_count == BIT_CNT_W'(SPI_FRAME_BITS - 1));
  // Byte-boundary reload only once a full byte has gone by in this selection
  assign w_load     = w_cs_fall | (w_fall & (r_bit_count == '0) & r_byte_done);
  assign w_shift    = w_fall & ~w_load;
  assign w_tx_next  = bus.spi_tx_strobe ? bus.spi_tx_data :
                      (r_hold_valid ? r_tx_hold : FILL_BYTE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_strobe   <= 1'b0;
      r_bit_count   <= '0;
      r_byte_done   <= 1'b0;
      r_tx_shift    <= '0;
      r_tx_hold     <= '0;
      r_hold_valid  <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_rx_strobe   <= 1'b0;
      r_tx_underrun <= 1'b0;
      if (!w_sel) begin
        r_bit_count <= '0;
        r_byte_done <= 1'b0;
        r_tx_shift  <= '0;
      end else begin
        if (w_rise) begin
          r_rx_shift  <= {r_rx_shift[SPI_FRAME_BITS-3:0], w_copi_s};
          r_bit_count <= r_bit_count + 1'b1;
          if (w_last_bit) begin
            r_rx_data   <= {r_rx_shift, w_copi_s};
            r_rx_strobe <= 1'b1;
            r_byte_done <= 1'b1;
          end
        end
        if (w_load) begin
          r_tx_shift <= w_tx_next;
        end else if (w_shift) begin
          r_tx_shift <= {r_tx_shift[SPI_FRAME_BITS-2:0], 1'b0};
        end
      end
      // Held response survives deselect so a late reply goes out next select
      if (w_load) begin
        r_hold_valid  <= 1'b0;
        r_tx_underrun <= ~r_hold_valid & ~bus.spi_tx_strobe;
      end else if (bus.spi_tx_strobe) begin
        r_tx_hold    <= bus.spi_tx_data;
        r_hold_valid <= 1'b1;
      end
    end
  end

  assign bus.spi_cipo      = w_sel & r_tx_shift[SPI_FRAME_BITS-1];
  assign bus.spi_rx_data   = r_rx_data;
  assign bus.spi_rx_strobe = r_rx_strobe;
  assign bus.tx_underrun   = r_tx_underrun;
endmodule
`default_nettype wire
